// File: rtl/change_monitor.sv
// change_monitor
//   Multi-channel value-change monitor. Every clock the CHANNELS sampled
//   buses are compared with the previously registered values. Each change
//   is captured as {channel, new value, timestamp} in a per-channel pending
//   slot. An arbiter then moves the slot into an event FIFO, and a
//   valid/ready port drains that FIFO.
//
// Ports
//   clock        rising-edge clock
//   reset_n      asynchronous active-low reset
//   enable       monitoring enable; low freezes prev and disarms detection
//   sample_in    CHANNELS*WIDTH; channel c at [c*WIDTH +: WIDTH]
//   out_valid    FIFO non-empty
//   out_ready    consumer accepts the head entry
//   out_channel  head entry channel index
//   out_value    head entry new value
//   out_time     head entry timestamp
//   count        FIFO occupancy (0..DEPTH)
//   overflow     sticky flag: a pending change was overwritten and lost
module change_monitor #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 8,
    parameter int TS_WIDTH = 16,
    localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int AW      = $clog2(DEPTH),
    localparam int CNT_W   = AW + 1
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         enable,
    input  logic [CHANNELS*WIDTH-1:0]    sample_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CW-1:0]                out_channel,
    output logic [WIDTH-1:0]             out_value,
    output logic [TS_WIDTH-1:0]          out_time,
    output logic [CNT_W-1:0]             count,
    output logic                         overflow
);

    // Channel-indexed view of the sample bus (element c == bits [c*WIDTH +: WIDTH]).
    logic [CHANNELS-1:0][WIDTH-1:0]    samp_s;

    // Sampling / change-capture state.
    logic [CHANNELS-1:0][WIDTH-1:0]    prev_q,  prev_d;
    logic                              armed_q, armed_d;
    logic [CHANNELS-1:0]               pend_q,  pend_d;
    logic [CHANNELS-1:0][WIDTH-1:0]    pval_q,  pval_d;
    logic [CHANNELS-1:0][TS_WIDTH-1:0] ptime_q, ptime_d;
    logic [TS_WIDTH-1:0]               ts_q,    ts_d;
    logic                              overflow_q, overflow_d;

    // Event FIFO storage and pointers.
    logic [DEPTH-1:0][CW-1:0]          mem_ch_q,  mem_ch_d;
    logic [DEPTH-1:0][WIDTH-1:0]       mem_val_q, mem_val_d;
    logic [DEPTH-1:0][TS_WIDTH-1:0]    mem_tm_q,  mem_tm_d;
    logic [AW-1:0]                     wr_ptr_q,  wr_ptr_d;
    logic [AW-1:0]                     rd_ptr_q,  rd_ptr_d;
    logic [CNT_W-1:0]                  count_q,   count_d;

    // Registered head-of-FIFO outputs.
    logic                              out_valid_q,   out_valid_d;
    logic [CW-1:0]                     out_channel_q, out_channel_d;
    logic [WIDTH-1:0]                  out_value_q,   out_value_d;
    logic [TS_WIDTH-1:0]               out_time_q,    out_time_d;

    // Combinational decisions for the current edge.
    logic [CHANNELS-1:0]               chg_s;
    logic [CHANNELS-1:0]               grant_s;
    logic [CW-1:0]                     grant_idx_s;
    logic                              grant_any_s;
    logic                              push_s;
    logic                              pop_s;
    logic                              ovf_hit_s;

    assign samp_s = sample_in;

    // Change detection: only when enabled and armed by a previous enabled edge.
    always_comb begin
        chg_s = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (enable && armed_q && (samp_s[c] != prev_q[c])) begin
                chg_s[c] = 1'b1;
            end else begin
                chg_s[c] = 1'b0;
            end
        end
    end

    // Fixed-priority arbiter: lowest-index pending channel wins the single write slot.
    always_comb begin
        grant_s     = '0;
        grant_idx_s = '0;
        grant_any_s = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (pend_q[c] && !grant_any_s) begin
                grant_any_s = 1'b1;
                grant_s[c]  = 1'b1;
                grant_idx_s = CW'(c);
            end else begin
                grant_s[c]  = 1'b0;
            end
        end
        // A full FIFO blocks the push even if a pop happens on the same edge.
        push_s = grant_any_s && (count_q < CNT_W'(DEPTH));
        pop_s  = out_valid_q && out_ready;
    end

    // Pending-slot update, prev/armed sampling, timestamp and sticky overflow.
    always_comb begin
        pend_d    = pend_q;
        pval_d    = pval_q;
        ptime_d   = ptime_q;
        ovf_hit_s = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (chg_s[c]) begin
                // A change replacing an entry that is not leaving this edge loses it.
                if (pend_q[c] && !(push_s && grant_s[c])) begin
                    ovf_hit_s = 1'b1;
                end else begin
                    ovf_hit_s = ovf_hit_s;
                end
                pend_d[c]  = 1'b1;
                pval_d[c]  = samp_s[c];
                ptime_d[c] = ts_q;
            end else if (push_s && grant_s[c]) begin
                pend_d[c]  = 1'b0;
            end else begin
                pend_d[c]  = pend_q[c];
            end
        end
        if (enable) begin
            prev_d  = samp_s;
            armed_d = 1'b1;
        end else begin
            prev_d  = prev_q;
            armed_d = 1'b0;
        end
        ts_d       = ts_q + TS_WIDTH'(1);
        overflow_d = overflow_q | ovf_hit_s;
    end

    // FIFO write, pointer/count update and next head-of-queue output values.
    always_comb begin
        mem_ch_d  = mem_ch_q;
        mem_val_d = mem_val_q;
        mem_tm_d  = mem_tm_q;
        if (push_s) begin
            mem_ch_d[wr_ptr_q]  = grant_idx_s;
            mem_val_d[wr_ptr_q] = pval_q[grant_idx_s];
            mem_tm_d[wr_ptr_q]  = ptime_q[grant_idx_s];
            wr_ptr_d            = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d            = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        out_valid_d = (count_d != CNT_W'(0));
        // Read the head from the post-write image so a push into an empty
        // queue is visible on the outputs right after the same edge.
        if (out_valid_d) begin
            out_channel_d = mem_ch_d[rd_ptr_d];
            out_value_d   = mem_val_d[rd_ptr_d];
            out_time_d    = mem_tm_d[rd_ptr_d];
        end else begin
            out_channel_d = out_channel_q;
            out_value_d   = out_value_q;
            out_time_d    = out_time_q;
        end
    end

    // State register for sampling, pending slots, timestamp and overflow.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev_q     <= '0;
            armed_q    <= 1'b0;
            pend_q     <= '0;
            pval_q     <= '0;
            ptime_q    <= '0;
            ts_q       <= '0;
            overflow_q <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            armed_q    <= armed_d;
            pend_q     <= pend_d;
            pval_q     <= pval_d;
            ptime_q    <= ptime_d;
            ts_q       <= ts_d;
            overflow_q <= overflow_d;
        end
    end

    // State register for the FIFO and its registered head outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_ch_q      <= '0;
            mem_val_q     <= '0;
            mem_tm_q      <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            out_valid_q   <= 1'b0;
            out_channel_q <= '0;
            out_value_q   <= '0;
            out_time_q    <= '0;
        end else begin
            mem_ch_q      <= mem_ch_d;
            mem_val_q     <= mem_val_d;
            mem_tm_q      <= mem_tm_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            out_valid_q   <= out_valid_d;
            out_channel_q <= out_channel_d;
            out_value_q   <= out_value_d;
            out_time_q    <= out_time_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_channel = out_channel_q;
    assign out_value   = out_value_q;
    assign out_time    = out_time_q;
    assign count       = count_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_change_monitor.sv
// Bench for change_monitor: directed scenarios followed by random traffic,
// all compared against an event-level reference model (queue of events).
module tb_change_monitor;

    localparam int WIDTH    = 4;
    localparam int CHANNELS = 2;
    localparam int DEPTH    = 8;
    localparam int TS_WIDTH = 4;
    localparam int CW       = 1;
    localparam int CNT_W    = 4;

    logic                      clock     = 1'b0;
    logic                      reset_n   = 1'b0;
    logic                      enable    = 1'b0;
    logic [CHANNELS*WIDTH-1:0] sample_in = '0;
    logic                      out_ready = 1'b0;
    logic                      out_valid;
    logic [CW-1:0]             out_channel;
    logic [WIDTH-1:0]          out_value;
    logic [TS_WIDTH-1:0]       out_time;
    logic [CNT_W-1:0]          count;
    logic                      overflow;

    int n_checks = 0;
    int n_fail   = 0;

    change_monitor #(
        .WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH), .TS_WIDTH(TS_WIDTH)
    ) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .sample_in(sample_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_channel(out_channel),
        .out_value(out_value), .out_time(out_time), .count(count), .overflow(overflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        int ch;
        int val;
        int tm;
    } ev_t;

    // Reference model state: one pending slot per channel and a queue of events.
    ev_t fifo[$];
    ev_t got[$];
    int  m_prev[CHANNELS];
    int  m_pval[CHANNELS];
    int  m_ptime[CHANNELS];
    bit  m_pend[CHANNELS];
    bit  m_armed;
    bit  m_ovf;
    int  m_ts;
    int  e_ch, e_val, e_tm;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        fifo.delete();
        for (int c = 0; c < CHANNELS; c++) begin
            m_prev[c] = 0; m_pval[c] = 0; m_ptime[c] = 0; m_pend[c] = 1'b0;
        end
        m_armed = 1'b0; m_ovf = 1'b0; m_ts = 0;
        e_ch = 0; e_val = 0; e_tm = 0;
    endtask

    // One clock edge of the event-level behaviour, using the current inputs.
    task automatic model_edge();
        int  g;
        int  s;
        ev_t e;
        g = -1;
        if (fifo.size() < DEPTH) begin
            for (int c = 0; c < CHANNELS; c++) if (m_pend[c] && g < 0) g = c;
        end
        if (fifo.size() > 0 && out_ready) void'(fifo.pop_front());
        if (g >= 0) begin
            e.ch = g; e.val = m_pval[g]; e.tm = m_ptime[g];
            fifo.push_back(e);
            m_pend[g] = 1'b0;
        end
        for (int c = 0; c < CHANNELS; c++) begin
            s = int'(sample_in[c*WIDTH +: WIDTH]);
            if (enable && m_armed && s != m_prev[c]) begin
                if (m_pend[c]) m_ovf = 1'b1;
                m_pend[c] = 1'b1; m_pval[c] = s; m_ptime[c] = m_ts;
            end
            if (enable) m_prev[c] = s;
        end
        m_armed = enable;
        m_ts = (m_ts + 1) % (1 << TS_WIDTH);
        if (fifo.size() > 0) begin
            e_ch = fifo[0].ch; e_val = fifo[0].val; e_tm = fifo[0].tm;
        end
    endtask

    task automatic model_check();
        chk("valid",    32'(out_valid),   32'(fifo.size() > 0));
        chk("count",    32'(count),       32'(fifo.size()));
        chk("overflow", 32'(overflow),    32'(m_ovf));
        chk("channel",  32'(out_channel), 32'(e_ch));
        chk("value",    32'(out_value),   32'(e_val));
        chk("time",     32'(out_time),    32'(e_tm));
    endtask

    // Advance one clock: record any DUT handshake, update model, compare after the edge.
    task automatic step();
        ev_t e;
        if (out_valid && out_ready) begin
            e.ch = int'(out_channel); e.val = int'(out_value); e.tm = int'(out_time);
            got.push_back(e);
        end
        model_edge();
        @(posedge clock);
        #1;
        model_check();
    endtask

    initial begin
        int t10;
        model_reset();
        #12;
        reset_n = 1'b1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count),     32'd0);

        // Arming: disabled edges t0,t1; hold 0 at t2..t4; change at t5.
        step(); step();
        enable = 1'b1; sample_in = 8'h00;
        step(); step(); step();
        chk("arm_hold_valid", 32'(out_valid), 32'd0);
        sample_in = 8'h01;
        step();
        chk("arm_t5_valid", 32'(out_valid), 32'd0);
        step();
        chk("arm_ev_valid", 32'(out_valid),   32'd1);
        chk("arm_ev_ch",    32'(out_channel), 32'd0);
        chk("arm_ev_val",   32'(out_value),   32'd1);
        chk("arm_ev_time",  32'(out_time),    32'd5);
        chk("arm_ev_count", 32'(count),       32'd1);

        // Simultaneous changes at t10, ch0 -> 1 and ch1 -> F.
        out_ready = 1'b1;
        sample_in = 8'h00;
        step(); step(); step();
        got.delete();
        sample_in = 8'hF1;
        step(); step(); step(); step();
        chk("sim_n",     32'(got.size()), 32'd2);
        if (got.size() == 2) begin
            chk("sim_ch0",   32'(got[0].ch),  32'd0);
            chk("sim_val0",  32'(got[0].val), 32'd1);
            chk("sim_t0",    32'(got[0].tm),  32'd10);
            chk("sim_ch1",   32'(got[1].ch),  32'd1);
            chk("sim_val1",  32'(got[1].val), 32'd15);
            chk("sim_t1",    32'(got[1].tm),  32'd10);
        end
        chk("sim_ovf", 32'(overflow), 32'd0);

        // Back-pressure: DEPTH+2 changes on ch0 with the consumer stalled.
        out_ready = 1'b0;
        t10 = 0;
        for (int k = 0; k < DEPTH + 2; k++) begin
            sample_in[3:0] = 4'(k + 2);
            if (k == DEPTH + 1) t10 = m_ts;
            step(); step();
        end
        chk("bp_count", 32'(count),    32'd8);
        chk("bp_ovf",   32'(overflow), 32'd1);
        out_ready = 1'b1;
        got.delete();
        for (int k = 0; k < 12; k++) step();
        chk("bp_n", 32'(got.size()), 32'd9);
        if (got.size() == 9) begin
            for (int k = 0; k < 8; k++) chk("bp_order", 32'(got[k].val), 32'(k + 2));
            chk("bp_last_val",  32'(got[8].val), 32'd11);
            chk("bp_last_time", 32'(got[8].tm),  32'(t10));
        end

        // Disable and rearm.
        sample_in[3:0] = 4'h1;
        step(); step(); step();
        enable = 1'b0; sample_in[3:0] = 4'h7;
        step(); step();
        enable = 1'b1;
        step();
        got.delete();
        step();
        sample_in[3:0] = 4'h3;
        step(); step(); step(); step();
        chk("rearm_n", 32'(got.size()), 32'd1);
        if (got.size() == 1) chk("rearm_val", 32'(got[0].val), 32'd3);

        // Timestamp wrap: changes on ch1 at t=15 and t=0.
        for (int k = 0; k < 20 && m_ts != 15; k++) step();
        got.delete();
        sample_in[7:4] = 4'h5;
        step();
        sample_in[7:4] = 4'h6;
        step(); step(); step(); step();
        chk("wrap_n", 32'(got.size()), 32'd2);
        if (got.size() == 2) begin
            chk("wrap_t15", 32'(got[0].tm), 32'd15);
            chk("wrap_t0",  32'(got[1].tm), 32'd0);
        end

        // Reset mid-operation with three queued events.
        out_ready = 1'b0;
        sample_in = 8'h10;
        step();
        sample_in = 8'h24;
        step(); step(); step();
        chk("mid_count", 32'(count),    32'd3);
        chk("mid_ovf",   32'(overflow), 32'd1);
        reset_n = 1'b0;
        #2;
        chk("arst_valid", 32'(out_valid),   32'd0);
        chk("arst_count", 32'(count),       32'd0);
        chk("arst_ovf",   32'(overflow),    32'd0);
        chk("arst_val",   32'(out_value),   32'd0);
        chk("arst_time",  32'(out_time),    32'd0);
        chk("arst_ch",    32'(out_channel), 32'd0);
        reset_n = 1'b1;
        model_reset();
        sample_in = 8'h77;
        step();
        chk("post_rst_arm", 32'(out_valid), 32'd0);
        step();
        chk("post_rst_idle", 32'(count), 32'd0);

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            enable    = ($urandom_range(0, 9) != 0);
            out_ready = ($urandom_range(0, 1) != 0);
            for (int c = 0; c < CHANNELS; c++) begin
                if ($urandom_range(0, 2) == 0) sample_in[c*WIDTH +: WIDTH] = 4'($urandom);
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
